// File: rtl/cdpga_clk_ctrl.sv
// cdpga_clk_ctrl
//   PLL lock supervisor, sequenced system-reset generator and fractional
//   clock-enable tick generator for the cdpga_bx fabric.
//
// Ports
//   clk        PLL global output clock (only clock)
//   reset_n    asynchronous active-low reset for every flop
//   pll_lock   PLL LOCK, asynchronous to clk
//   lock_clr   single-cycle pulse, clears lock_lost
//   ch_en      per-channel tick enable
//   ch_inc     per-channel phase increment, channel i at [i*ACC_W +: ACC_W]
//   sys_rst_n  system reset, active-low, released synchronously
//   ready      high while the block is running
//   lock_lost  sticky flag: lock dropped during HOLD or RUN
//   loss_cnt   saturating count of lock losses in HOLD/RUN
//   tick       one-cycle clock-enable pulses, one per channel
//
// State table
//   state     | meaning
//   ----------+-------------------------------------------------------
//   WAIT_LOCK | waiting for synchronised lock
//   STABLE    | qualifying lock for LOCK_CYC consecutive cycles
//   HOLD      | lock qualified, keeping sys_rst_n low
//   RUN       | clock trusted, system out of reset, ticks enabled
//
// sys_rst_n/ready are registered from state==RUN and so lag the state by
// one cycle. HOLD therefore lasts RST_HOLD-1 cycles so that sys_rst_n is
// low for exactly RST_HOLD cycles after qualification; with RST_HOLD=1
// HOLD is skipped.

module cdpga_clk_ctrl #(
  parameter int N_CH     = 2,
  parameter int ACC_W    = 24,
  parameter int LOCK_CYC = 1024,
  parameter int RST_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_lock,
  input  logic                    lock_clr,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH*ACC_W-1:0]   ch_inc,
  output logic                    sys_rst_n,
  output logic                    ready,
  output logic                    lock_lost,
  output logic [7:0]              loss_cnt,
  output logic [N_CH-1:0]         tick
);

  localparam int QW = $clog2(LOCK_CYC + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int CW = (QW > HW) ? QW : HW;

  localparam logic [CW-1:0] QUAL_LAST = CW'(LOCK_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((RST_HOLD >= 2) ? (RST_HOLD - 2) : 0);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            loss_evt;
  logic            lock_meta, lock_s;
  logic            run_q;
  logic            acc_go;

  logic [ACC_W-1:0] acc     [N_CH];
  logic [ACC_W:0]   acc_sum [N_CH];

  // Lock synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_evt  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        // A drop here is chatter during qualification, not a loss event.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == QUAL_LAST) begin
          state_nxt = (RST_HOLD == 1) ? RUN : HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          loss_evt  = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          loss_evt  = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered RUN decode plus loss bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      lock_lost <= 1'b0;
      loss_cnt  <= 8'd0;
    end else begin
      run_q <= (state == RUN);
      // Set wins over a simultaneous clear.
      if (loss_evt)      lock_lost <= 1'b1;
      else if (lock_clr) lock_lost <= 1'b0;
      if (loss_evt && (loss_cnt != 8'hFF)) loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign sys_rst_n = run_q;
  assign ready     = run_q;

  // Accumulate only once sys_rst_n is already high and the FSM is still
  // in RUN: the first accumulate lands on the edge after sys_rst_n rises,
  // and ticks stop on the edge after the FSM leaves RUN.
  assign acc_go = run_q && (state == RUN);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      acc_sum[i] = {1'b0, acc[i]} + {1'b0, ch_inc[i*ACC_W +: ACC_W]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      tick <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (acc_go && ch_en[i]) begin
          acc[i]  <= acc_sum[i][ACC_W-1:0];
          tick[i] <= acc_sum[i][ACC_W];
        end else begin
          acc[i]  <= '0;
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule
